ctrl_decode_pipe: RTL and testbench
===================================

CTRL_DECODE_PIPE -- requirements
Module: ctrl_decode_pipe

Interface
REQ-001 SHALL have parameter ENABLE_M, default 0, enables RV32M decode (1) or treats M ops as illegal (0).
REQ-002 SHALL have parameter ALU_SEL_W, derived as 4+ENABLE_M, giving the width of AluSel_o.
REQ-003 clk_i  in  1  single clock; every register samples on the rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 inst_i  in  32  instruction word; qualified by in_valid_i.
REQ-006 in_valid_i  in  1 / in_ready_o  out  1  input handshake; transfer when both are 1.
REQ-007 out_valid_o  out  1 / out_ready_i  in  1  output handshake; transfer when both are 1.
REQ-008 flush_i  in  1  discards all buffered and same-cycle input entries.
REQ-009 RegWEn_o  out  1  register-file write enable.
REQ-010 MemRW_o  out  1  data-memory write (1 = store).
REQ-011 AluSel_o  out  ALU_SEL_W  ALU operation code.
REQ-012 ImmSel_o  out  3  immediate format.
REQ-013 BSel_o  out  1  ALU B operand source (1 = immediate).
REQ-014 inst_o  out  32  instruction word carried with its control bundle.
REQ-015 illegal_o  out  1  head entry is illegal.
REQ-016 illegal_cnt_o  out  8  saturating count of illegal instructions.

Function
REQ-017 SHALL decode combinationally on input and store {inst, controls, illegal} in a 2-entry FIFO; outputs SHALL be driven from the FIFO head only.
REQ-018 Latency SHALL be 1 cycle: an entry accepted in cycle N SHALL be visible with out_valid_o=1 in cycle N+1 when the FIFO was empty.
REQ-019 in_ready_o SHALL equal (count<2) and SHALL depend only on registered state.
REQ-020 Counts: push only -> +1; pop only -> -1; simultaneous push and pop -> unchanged, with FIFO order preserved.
REQ-021 out_valid_o SHALL equal (count>0); outputs SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-022 R-type (0110011) SHALL decode to AluSel={funct7[5],funct3} (zero-extended MSB when ALU_SEL_W=5), RegWEn=1, BSel=0, ImmSel=7.
REQ-023 With ENABLE_M=1, funct7=0000001 R-type SHALL decode to AluSel={1'b1,1'b0,funct3}.
REQ-024 I-arith (0010011) SHALL decode to AluSel={(funct3==101)&funct7[5],funct3}, BSel=1, ImmSel=0, RegWEn=1.
REQ-025 Load (0000011)/JALR (1100111): AluSel=0, ImmSel=0, BSel=1, RegWEn=1. Store (0100011): ImmSel=1, MemRW=1, RegWEn=0. Branch (1100011): ImmSel=2, RegWEn=0.
REQ-026 LUI (0110111): AluSel=1111 (pass B), ImmSel=3. AUIPC (0010111): AluSel=0, ImmSel=3. JAL (1101111): ImmSel=4. All three SHALL decode with BSel=1, RegWEn=1.
REQ-027 Illegal cases SHALL be:
- any other opcode;
- R-type funct7 not in {0000000, 0100000 with funct3 in {000,101}, 0000001 when ENABLE_M=1}.
REQ-028 An illegal entry SHALL carry illegal=1, RegWEn=0, MemRW=0, AluSel=0, ImmSel=7, BSel=0.
REQ-029 illegal_cnt_o SHALL increment once per accepted, non-flushed illegal instruction and SHALL saturate at 255.
REQ-030 flush_i=1 SHALL set count to 0 on the next edge, drop any same-cycle push (not counted), suppress the same-cycle pop, and leave illegal_cnt_o unchanged except as REQ-029 allows.

Reset
REQ-031 rst_i=1 SHALL immediately clear count, out_valid_o, RegWEn_o, MemRW_o, BSel_o, illegal_o, AluSel_o, inst_o and illegal_cnt_o to 0, set ImmSel_o=7, and force in_ready_o=1 after release.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered entries; no partial entry SHALL survive.

Verification
REQ-033 Push 0x40B50533 (sub) with out_ready_i=1 -> next cycle out_valid_o=1, AluSel_o=1000, RegWEn_o=1, BSel_o=0.
REQ-034 Hold out_ready_i=0 and push three valid instructions -> in_ready_o=0 after two; third held off; release -> entries pop in order.
REQ-035 ENABLE_M=0: push 0x02B50533 (mul) -> illegal_o=1, RegWEn_o=0, illegal_cnt_o=1; ENABLE_M=1 -> AluSel_o=10000, illegal_o=0.
REQ-036 Fill FIFO, assert flush_i together with an illegal push -> count=0 next cycle, illegal_cnt_o unchanged.
REQ-037 Push 260 illegal words (0xFFFFFFFF) -> illegal_cnt_o=255; assert rst_i mid-stream -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/ctrl_decode_pipe.sv
// Instruction decode stage: combinational RV32I(+M) control decode into a 2-entry FIFO,
// with valid/ready handshakes on both sides and a saturating illegal-instruction counter.
module ctrl_decode_pipe #(
  parameter int ENABLE_M  = 0,
  parameter int ALU_SEL_W = 4 + ENABLE_M
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          inst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  input  logic                 flush_i,
  output logic                 RegWEn_o,
  output logic                 MemRW_o,
  output logic [ALU_SEL_W-1:0] AluSel_o,
  output logic [2:0]           ImmSel_o,
  output logic                 BSel_o,
  output logic [31:0]          inst_o,
  output logic                 illegal_o,
  output logic [7:0]           illegal_cnt_o
);

  typedef struct packed {
    logic [31:0]          inst;
    logic                 illegal;
    logic                 regwen;
    logic                 memrw;
    logic [ALU_SEL_W-1:0] alusel;
    logic [2:0]           immsel;
    logic                 bsel;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  entry_t     dec;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  // Decoded fields default to the illegal/idle encoding; each legal opcode overrides.
  always_comb begin
    dec         = '0;
    dec.inst    = inst_i;
    dec.immsel  = 3'd7;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec.regwen = 1'b1;
          dec.alusel = ALU_SEL_W'({1'b0, funct7[5], funct3});
        end else if (ENABLE_M != 0 && funct7 == 7'b0000001) begin
          dec.regwen = 1'b1;
          dec.alusel = ALU_SEL_W'({2'b10, funct3});
        end else begin
          dec.illegal = 1'b1;
        end
      end
      7'b0010011: begin
        dec.regwen = 1'b1;
        dec.bsel   = 1'b1;
        dec.immsel = 3'd0;
        dec.alusel = ALU_SEL_W'({1'b0, (funct3 == 3'b101) & funct7[5], funct3});
      end
      7'b0000011, 7'b1100111: begin
        dec.regwen = 1'b1;
        dec.bsel   = 1'b1;
        dec.immsel = 3'd0;
      end
      7'b0100011: begin
        dec.memrw  = 1'b1;
        dec.bsel   = 1'b1;
        dec.immsel = 3'd1;
      end
      7'b1100011: begin
        dec.immsel = 3'd2;
      end
      7'b0110111: begin
        dec.regwen = 1'b1;
        dec.bsel   = 1'b1;
        dec.immsel = 3'd3;
        dec.alusel = ALU_SEL_W'(5'b01111);
      end
      7'b0010111: begin
        dec.regwen = 1'b1;
        dec.bsel   = 1'b1;
        dec.immsel = 3'd3;
      end
      7'b1101111: begin
        dec.regwen = 1'b1;
        dec.bsel   = 1'b1;
        dec.immsel = 3'd4;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  entry_t     fifo_q [2];
  logic [1:0] count_q;
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic       push;
  logic       pop;
  entry_t     head;

  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign push        = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q       <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      illegal_cnt_o <= 8'd0;
    end else begin
      if (flush_i) begin
        count_q  <= 2'd0;
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
        case ({push, pop})
          2'b10:   count_q <= count_q + 2'd1;
          2'b01:   count_q <= count_q - 2'd1;
          default: count_q <= count_q;
        endcase
      end
      if (push && dec.illegal && illegal_cnt_o != 8'hFF)
        illegal_cnt_o <= illegal_cnt_o + 8'd1;
    end
  end

  // Payload storage needs no reset: it is only visible through the count-gated head mux.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= dec;
  end

  always_comb begin
    head        = '0;
    head.immsel = 3'd7;
    if (out_valid_o) head = fifo_q[rd_ptr_q];
  end

  assign RegWEn_o  = head.regwen;
  assign MemRW_o   = head.memrw;
  assign AluSel_o  = head.alusel;
  assign ImmSel_o  = head.immsel;
  assign BSel_o    = head.bsel;
  assign inst_o    = head.inst;
  assign illegal_o = head.illegal;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed bench for ctrl_decode_pipe; one instance without and one with the M extension
// share identical stimulus.
module tb_ctrl_decode_pipe;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic        in_valid;
  logic        out_ready;
  logic        flush;

  logic        in_ready,  out_valid,  regwen,  memrw,  bsel,  illegal;
  logic [3:0]  alusel;
  logic [2:0]  immsel;
  logic [31:0] inst_out;
  logic [7:0]  ill_cnt;

  logic        in_ready_m, out_valid_m, regwen_m, memrw_m, bsel_m, illegal_m;
  logic [4:0]  alusel_m;
  logic [2:0]  immsel_m;
  logic [31:0] inst_out_m;
  logic [7:0]  ill_cnt_m;

  int errors = 0;
  int checks = 0;

  ctrl_decode_pipe #(.ENABLE_M(0)) dut (
    .clk_i(clk), .rst_i(rst), .inst_i(inst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .flush_i(flush), .RegWEn_o(regwen),
    .MemRW_o(memrw), .AluSel_o(alusel), .ImmSel_o(immsel), .BSel_o(bsel), .inst_o(inst_out),
    .illegal_o(illegal), .illegal_cnt_o(ill_cnt)
  );

  ctrl_decode_pipe #(.ENABLE_M(1)) dut_m (
    .clk_i(clk), .rst_i(rst), .inst_i(inst), .in_valid_i(in_valid), .in_ready_o(in_ready_m),
    .out_valid_o(out_valid_m), .out_ready_i(out_ready), .flush_i(flush), .RegWEn_o(regwen_m),
    .MemRW_o(memrw_m), .AluSel_o(alusel_m), .ImmSel_o(immsel_m), .BSel_o(bsel_m),
    .inst_o(inst_out_m), .illegal_o(illegal_m), .illegal_cnt_o(ill_cnt_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] SUB  = 32'h40B50533;
  localparam logic [31:0] MUL  = 32'h02B50533;
  localparam logic [31:0] ADDI = 32'h00150513;
  localparam logic [31:0] LUI  = 32'h123452B7;
  localparam logic [31:0] SW   = 32'h00B52023;
  localparam logic [31:0] BAD  = 32'hFFFFFFFF;

  initial begin
    rst = 1'b1; inst = '0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_immsel",    32'(immsel),    32'd7);
    chk("rst_alusel",    32'(alusel),    32'd0);
    chk("rst_inst",      inst_out,       32'd0);
    chk("rst_ill_cnt",   32'(ill_cnt),   32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // sub: one-cycle latency, then drains
    inst = SUB; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sub_valid",  32'(out_valid), 32'd1);
    chk("sub_alusel", 32'(alusel),    32'h8);
    chk("sub_regwen", 32'(regwen),    32'd1);
    chk("sub_bsel",   32'(bsel),      32'd0);
    chk("sub_immsel", 32'(immsel),    32'd7);
    chk("sub_inst",   inst_out,       SUB);
    chk("sub_alusel_m", 32'(alusel_m), 32'h08);
    tick();
    chk("sub_drained", 32'(out_valid), 32'd0);

    // mul: illegal without M, legal with M
    inst = MUL; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mul_illegal",    32'(illegal),   32'd1);
    chk("mul_regwen",     32'(regwen),    32'd0);
    chk("mul_alusel",     32'(alusel),    32'd0);
    chk("mul_immsel",     32'(immsel),    32'd7);
    chk("mul_ill_cnt",    32'(ill_cnt),   32'd1);
    chk("mul_m_alusel",   32'(alusel_m),  32'h10);
    chk("mul_m_illegal",  32'(illegal_m), 32'd0);
    chk("mul_m_regwen",   32'(regwen_m),  32'd1);
    chk("mul_m_ill_cnt",  32'(ill_cnt_m), 32'd0);
    tick();

    // backpressure: two accepted, third held off, drain in order
    out_ready = 1'b0; inst = ADDI; in_valid = 1'b1;
    tick();
    chk("bp_ready_after1", 32'(in_ready), 32'd1);
    inst = LUI;
    tick();
    chk("bp_ready_after2", 32'(in_ready), 32'd0);
    inst = SW;
    tick();
    chk("bp_held_ready",  32'(in_ready), 32'd0);
    chk("bp_head_addi",   inst_out,      ADDI);
    chk("bp_addi_bsel",   32'(bsel),     32'd1);
    chk("bp_addi_immsel", 32'(immsel),   32'd0);
    chk("bp_addi_alusel", 32'(alusel),   32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_head_lui",    inst_out,      LUI);
    chk("bp_lui_alusel",  32'(alusel),   32'hF);
    chk("bp_lui_immsel",  32'(immsel),   32'd3);
    chk("bp_ready_freed", 32'(in_ready), 32'd1);
    tick();
    chk("bp_head_sw",     inst_out,      SW);
    chk("bp_sw_memrw",    32'(memrw),    32'd1);
    chk("bp_sw_immsel",   32'(immsel),   32'd1);
    chk("bp_sw_regwen",   32'(regwen),   32'd0);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // flush of a full FIFO with an illegal word presented
    out_ready = 1'b0; inst = ADDI; in_valid = 1'b1;
    tick();
    tick();
    chk("fl_full", 32'(in_ready), 32'd0);
    inst = BAD; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid",     32'(out_valid), 32'd0);
    chk("fl_ready",     32'(in_ready),  32'd1);
    chk("fl_ill_cnt",   32'(ill_cnt),   32'd1);
    chk("fl_ill_cnt_m", 32'(ill_cnt_m), 32'd0);

    // flush while an illegal push would otherwise be accepted
    inst = ADDI; in_valid = 1'b1;
    tick();
    inst = BAD; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_valid",   32'(out_valid), 32'd0);
    chk("fl2_ill_cnt", 32'(ill_cnt),   32'd1);
    chk("fl2_ill_cnt_m", 32'(ill_cnt_m), 32'd0);

    // illegal counter saturation
    out_ready = 1'b1; inst = BAD; in_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      tick();
      if (i == 252) chk("sat_254", 32'(ill_cnt), 32'd254);
      if (i == 253) chk("sat_255", 32'(ill_cnt), 32'd255);
    end
    chk("sat_cnt",     32'(ill_cnt),   32'd255);
    chk("sat_cnt_m",   32'(ill_cnt_m), 32'd255);
    chk("sat_illegal", 32'(illegal),   32'd1);
    chk("sat_immsel",  32'(immsel),    32'd7);
    chk("sat_regwen",  32'(regwen),    32'd0);

    // asynchronous reset mid-stream, between clock edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid",   32'(out_valid), 32'd0);
    chk("arst_ill_cnt", 32'(ill_cnt),   32'd0);
    chk("arst_illegal", 32'(illegal),   32'd0);
    chk("arst_immsel",  32'(immsel),    32'd7);
    chk("arst_inst",    inst_out,       32'd0);
    chk("arst_ready",   32'(in_ready),  32'd1);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_ready", 32'(in_ready),  32'd1);
    chk("post_rst_cnt_m", 32'(ill_cnt_m), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
